operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have CLK, input, 1, rising-edge clock for all state.
REQ-002 SHALL have RESET, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have IN_VALID/IN_READY, input/output, 1 each, decoded-instruction handshake from decode.
REQ-004 SHALL have RAA and RBA, input, 5 each, source register addresses.
REQ-005 SHALL have MB, input, 1, selects IMM (1) or register RBA (0) as operand B.
REQ-006 SHALL have IMM, input, 32, pre-extended immediate.
REQ-007 SHALL have SH_IN, FS_IN, DA_IN, input, 5 each, shift amount, function select, destination; RW_IN, input, 1, register-write flag.
REQ-008 SHALL have WB_EN, input, 1; WB_ADDR, input, 5; WB_DATA, input, 32; write-back port.
REQ-009 SHALL have OUT_VALID, output, 1, and OUT_READY, input, 1, handshake to the function unit.
REQ-010 SHALL have A and B, output, 32 each; SH, FS, DA, output, 5 each; RW, output, 1; all registered.

Function
REQ-011 SHALL hold a 32 x 32-bit register file; R0 reads 0 always; writes to R0 ignored.
REQ-012 SHALL write WB_DATA to WB_ADDR on a rising edge when WB_EN=1 and WB_ADDR!=0.
REQ-013 SHALL keep a 32-bit pending scoreboard; on accept with RW_IN=1 and DA_IN!=0, bit DA_IN sets.
REQ-014 SHALL clear pending bit WB_ADDR on a rising edge with WB_EN=1; simultaneous set and clear of the same bit: set wins.
REQ-015 SHALL raise hazard when RAA!=0 and pending[RAA], or MB=0, RBA!=0 and pending[RBA], subject to REQ-025.
REQ-016 SHALL drive IN_READY = (!OUT_VALID or OUT_READY) and !hazard, combinationally.
REQ-017 SHALL accept when IN_VALID and IN_READY; accept loads A, B, SH, FS, DA, RW and sets OUT_VALID=1 next edge; latency 1 cycle.
REQ-018 SHALL load A = regfile[RAA]; B = IMM if MB=1, else regfile[RBA].
REQ-019 SHALL clear OUT_VALID when OUT_READY=1 and no accept occurs in the same cycle.
REQ-020 SHALL hold all outputs stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 SHALL accept back-to-back, one per cycle, when OUT_READY=1 and no hazard.
REQ-022 SHALL allow IN_VALID=0 cycles without changing the scoreboard except by write-back.

Reset
REQ-023 SHALL on RESET clear OUT_VALID, A, B, SH, FS, DA, RW, all 32 registers and all pending bits to 0.
REQ-024 SHALL give RESET priority over accept and write-back in the same cycle; IN_READY=0 while RESET=1; an in-flight output is discarded.

Configuration
REQ-025 SHALL, with macro OPERAND_FETCH_BYPASS_EN defined, forward WB_DATA to A/B when WB_EN=1 and WB_ADDR matches a nonzero source, and ignore that source's pending bit that cycle.
REQ-026 SHALL, without OPERAND_FETCH_BYPASS_EN, read pre-write register contents and treat the pending bit as set through the write-back cycle, stalling one extra cycle.

Verification
REQ-027 SHALL test reset: RESET=1 one edge with WB_EN=1, WB_ADDR=3 -> OUT_VALID=0, A=B=0, R3 reads 0, IN_READY=1 after release.
REQ-028 SHALL test basic: WB R5=0x0000_0010, then RAA=5, MB=1, IMM=0xFFFF_FFFF, FS_IN=0x02 -> next cycle OUT_VALID=1, A=0x10, B=0xFFFF_FFFF, FS=0x02.
REQ-029 SHALL test R0: WB_EN=1, WB_ADDR=0, WB_DATA=0x1234; RAA=0, RBA=0, MB=0 -> A=0, B=0, no hazard.
REQ-030 SHALL test hazard: issue RW_IN=1, DA_IN=7; next RAA=7 -> IN_READY=0 until WB R7=0xABCD; bypass build: accept in WB cycle with A=0xABCD; non-bypass: accept one cycle later.
REQ-031 SHALL test backpressure: OUT_READY=0 for 3 cycles with IN_VALID=1 -> outputs unchanged, IN_READY=0; OUT_READY=1 -> one transfer per cycle.
REQ-032 SHALL test same-cycle set and clear: WB R9 while accepting DA_IN=9, RW_IN=1 -> pending[9]=1 afterward; RAA=9 stalls.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register file + pending scoreboard + registered operand hand-off to the function unit
// Optional feature: define OPERAND_FETCH_BYPASS_EN to forward same-cycle write-back data into A/B
module operand_fetch_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [4:0]  RAA,
    input  logic [4:0]  RBA,
    input  logic        MB,
    input  logic [31:0] IMM,
    input  logic [4:0]  SH_IN,
    input  logic [4:0]  FS_IN,
    input  logic [4:0]  DA_IN,
    input  logic        RW_IN,
    input  logic        WB_EN,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  SH,
    output logic [4:0]  FS,
    output logic [4:0]  DA,
    output logic        RW
);
    logic [31:0] rf [32];
    logic [31:0] pending;
    logic        use_b, hit_a, hit_b, haz_a, haz_b, hazard, accept;
    logic [31:0] rd_a, rd_b, set_m, clr_m;

    // hazard detection, operand read and handshake
    always_comb begin
        use_b  = !MB && RBA != 5'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
        hit_a  = WB_EN && WB_ADDR == RAA && RAA != 5'd0;
        hit_b  = WB_EN && WB_ADDR == RBA && RBA != 5'd0;
`else
        hit_a  = 1'b0;
        hit_b  = 1'b0;
`endif
        haz_a  = RAA != 5'd0 && pending[RAA] && !hit_a;
        haz_b  = use_b && pending[RBA] && !hit_b;
        hazard = haz_a || haz_b;
        rd_a   = RAA == 5'd0 ? 32'd0 : hit_a ? WB_DATA : rf[RAA];
        rd_b   = MB ? IMM : RBA == 5'd0 ? 32'd0 : hit_b ? WB_DATA : rf[RBA];
        IN_READY = !RESET && (!OUT_VALID || OUT_READY) && !hazard;
        accept = IN_VALID && IN_READY;
        set_m  = accept && RW_IN && DA_IN != 5'd0 ? 32'd1 << DA_IN : 32'd0;
        clr_m  = WB_EN ? 32'd1 << WB_ADDR : 32'd0;
    end

    // register file write-back; R0 is never written so it always reads zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (WB_EN && WB_ADDR != 5'd0) begin
            rf[WB_ADDR] <= WB_DATA;
        end
    end

    // scoreboard: a new writer's set overrides a same-cycle write-back clear
    always_ff @(posedge CLK) begin
        if (RESET) pending <= 32'd0;
        else       pending <= (pending & ~clr_m) | set_m;
    end

    // output register: load on accept, drop when consumed, hold under backpressure
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            A  <= 32'd0;
            B  <= 32'd0;
            SH <= 5'd0;
            FS <= 5'd0;
            DA <= 5'd0;
            RW <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            A  <= rd_a;
            B  <= rd_b;
            SH <= SH_IN;
            FS <= FS_IN;
            DA <= DA_IN;
            RW <= RW_IN;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
    logic        CLK = 1'b0, RESET = 1'b0, IN_VALID = 1'b0, IN_READY;
    logic [4:0]  RAA = '0, RBA = '0, SH_IN = '0, FS_IN = '0, DA_IN = '0, WB_ADDR = '0;
    logic        MB = 1'b0, RW_IN = 1'b0, WB_EN = 1'b0, OUT_VALID, OUT_READY = 1'b1, RW;
    logic [31:0] IMM = '0, WB_DATA = '0, A, B;
    logic [4:0]  SH, FS, DA;
    int checks = 0, failures = 0;

    operand_fetch_stage dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RAA(RAA), .RBA(RBA), .MB(MB), .IMM(IMM), .SH_IN(SH_IN), .FS_IN(FS_IN),
        .DA_IN(DA_IN), .RW_IN(RW_IN), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .A(A), .B(B), .SH(SH), .FS(FS),
        .DA(DA), .RW(RW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAA=a with IN_VALID=1 must already be stalled on pending[a]; this drives the write-back of a
    task automatic wb_release(input logic [4:0] a, input logic [31:0] d, input string t);
        WB_EN = 1'b1; WB_ADDR = a; WB_DATA = d;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        chk({t, "_rdy_wb"}, {31'd0, IN_READY}, 32'd1);
        tick();
        WB_EN = 1'b0;
`else
        chk({t, "_rdy_wb"}, {31'd0, IN_READY}, 32'd0);
        tick();
        WB_EN = 1'b0;
        chk({t, "_ov_wb"}, {31'd0, OUT_VALID}, 32'd0);
        #1;
        chk({t, "_rdy_after"}, {31'd0, IN_READY}, 32'd1);
        tick();
`endif
        chk({t, "_ov"}, {31'd0, OUT_VALID}, 32'd1);
        chk({t, "_a"}, A, d);
    endtask

    initial begin
        // reset beats a simultaneous write-back and an offered instruction
        RESET = 1'b1; WB_EN = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'hDEAD_BEEF;
        IN_VALID = 1'b1; RAA = 5'd3;
        #1;
        chk("rst_rdy", {31'd0, IN_READY}, 32'd0);
        tick();
        RESET = 1'b0; WB_EN = 1'b0; IN_VALID = 1'b0;
        chk("rst_ov", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_a", A, 32'd0);
        chk("rst_b", B, 32'd0);
        #1;
        chk("rst_rdy_rel", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1; RAA = 5'd3; RBA = 5'd3; MB = 1'b0;
        tick();
        chk("rst_r3_a", A, 32'd0);
        chk("rst_r3_ov", {31'd0, OUT_VALID}, 32'd1);
        IN_VALID = 1'b0;
        tick();
        chk("drain_ov", {31'd0, OUT_VALID}, 32'd0);

        // basic fetch with immediate operand
        WB_EN = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'h0000_0010;
        tick();
        WB_EN = 1'b0;
        IN_VALID = 1'b1; RAA = 5'd5; MB = 1'b1; IMM = 32'hFFFF_FFFF;
        FS_IN = 5'h02; SH_IN = 5'd3; DA_IN = 5'd4; RW_IN = 1'b0;
        tick();
        chk("basic_ov", {31'd0, OUT_VALID}, 32'd1);
        chk("basic_a", A, 32'h10);
        chk("basic_b", B, 32'hFFFF_FFFF);
        chk("basic_fs", {27'd0, FS}, 32'h2);
        chk("basic_sh", {27'd0, SH}, 32'd3);
        chk("basic_da", {27'd0, DA}, 32'd4);
        chk("basic_rw", {31'd0, RW}, 32'd0);
        IN_VALID = 1'b0;
        tick();

        // R0 reads zero and write-back to it is ignored
        WB_EN = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'h1234;
        IN_VALID = 1'b1; RAA = 5'd0; RBA = 5'd0; MB = 1'b0;
        #1;
        chk("r0_rdy", {31'd0, IN_READY}, 32'd1);
        tick();
        WB_EN = 1'b0;
        chk("r0_a", A, 32'd0);
        chk("r0_b", B, 32'd0);
        tick();
        chk("r0_again_a", A, 32'd0);

        // RAW hazard on R7
        RW_IN = 1'b1; DA_IN = 5'd7; RAA = 5'd0; RBA = 5'd5; MB = 1'b0;
        tick();
        chk("haz_issue_b", B, 32'h10);
        chk("haz_issue_da", {27'd0, DA}, 32'd7);
        chk("haz_issue_rw", {31'd0, RW}, 32'd1);
        RW_IN = 1'b0; DA_IN = 5'd0; RAA = 5'd7; MB = 1'b1; IMM = 32'd0;
        #1;
        chk("haz_rdy0", {31'd0, IN_READY}, 32'd0);
        tick();
        chk("haz_ov0", {31'd0, OUT_VALID}, 32'd0);
        chk("haz_rdy1", {31'd0, IN_READY}, 32'd0);
        tick();
        wb_release(5'd7, 32'h0000_ABCD, "haz");
        IN_VALID = 1'b0;
        tick();

        // backpressure holds outputs, then back-to-back transfers
        IN_VALID = 1'b1; RAA = 5'd5; MB = 1'b1; IMM = 32'h11;
        tick();
        chk("bp_load_b", B, 32'h11);
        OUT_READY = 1'b0; IMM = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", {31'd0, IN_READY}, 32'd0);
            tick();
            chk("bp_hold_ov", {31'd0, OUT_VALID}, 32'd1);
            chk("bp_hold_b", B, 32'h11);
        end
        OUT_READY = 1'b1;
        #1;
        chk("bp_rdy_rel", {31'd0, IN_READY}, 32'd1);
        tick();
        chk("bp_b2", B, 32'h22);
        IMM = 32'h33;
        tick();
        chk("bp_b3", B, 32'h33);
        chk("bp_ov3", {31'd0, OUT_VALID}, 32'd1);
        IN_VALID = 1'b0;
        tick();
        chk("bp_drain", {31'd0, OUT_VALID}, 32'd0);

        // write-back of R9 coinciding with a new writer of R9 leaves it pending
        WB_EN = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'h99;
        IN_VALID = 1'b1; RW_IN = 1'b1; DA_IN = 5'd9; RAA = 5'd0; MB = 1'b1;
        tick();
        WB_EN = 1'b0; RW_IN = 1'b0; DA_IN = 5'd0; RAA = 5'd9;
        #1;
        chk("sc_rdy", {31'd0, IN_READY}, 32'd0);
        tick();
        chk("sc_ov", {31'd0, OUT_VALID}, 32'd0);
        wb_release(5'd9, 32'h77, "sc");

        // reset discards an in-flight output and clears registers and scoreboard
        RW_IN = 1'b1; DA_IN = 5'd12; RAA = 5'd5; RBA = 5'd5; MB = 1'b0;
        tick();
        chk("rst2_pre_a", A, 32'h10);
        RESET = 1'b1; IN_VALID = 1'b0; RW_IN = 1'b0;
        tick();
        RESET = 1'b0;
        chk("rst2_ov", {31'd0, OUT_VALID}, 32'd0);
        chk("rst2_a", A, 32'd0);
        IN_VALID = 1'b1; RAA = 5'd12; RBA = 5'd5; MB = 1'b0;
        #1;
        chk("rst2_rdy", {31'd0, IN_READY}, 32'd1);
        tick();
        chk("rst2_r5", B, 32'd0);
        IN_VALID = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
